// File: rtl/OoO_pkg.sv
// Shared backend types: CSR operation encoding and the CSR file port bundle.
package OoO_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic    csr_enable;
    csr_op_e csr_op;
  } csr_set_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;

endpackage

// File: rtl/ysyx_24080006_csr_ctrl_if.sv
// Bundle of dispatch, ROB-head, CSR-file and completion signals around the CSR controller.
interface ysyx_24080006_csr_ctrl_if #(
  parameter int unsigned ROB_IDX_W = 4
) ();

  logic                     flush;
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_kind;
  OoO_pkg::csr_op_e         req_op;
  logic [11:0]              req_csr;
  logic [31:0]              req_src;
  logic [31:0]              req_pc;
  logic [ROB_IDX_W-1:0]     req_rob;
  logic                     req_rd_en;
  logic                     rob_head_valid;
  logic [ROB_IDX_W-1:0]     rob_head;
  OoO_pkg::csr_set_t        csr_set;
  logic [11:0]              csr_name;
  logic [31:0]              csr_wdata;
  logic [31:0]              csr_pc;
  logic                     ecall;
  logic                     mret;
  logic [31:0]              csr_rdata;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [ROB_IDX_W-1:0]     wb_rob;
  logic                     wb_rd_en;
  logic [31:0]              wb_data;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;

  // The CSR controller side.
  modport slave (
    input  flush, req_valid, req_kind, req_op, req_csr, req_src, req_pc, req_rob, req_rd_en,
    input  rob_head_valid, rob_head, csr_rdata, wb_ready,
    output req_ready, csr_set, csr_name, csr_wdata, csr_pc, ecall, mret,
    output wb_valid, wb_rob, wb_rd_en, wb_data, redirect_valid, redirect_pc
  );

  // The surrounding pipeline: dispatch, ROB, CSR file and completion stage.
  modport master (
    output flush, req_valid, req_kind, req_op, req_csr, req_src, req_pc, req_rob, req_rd_en,
    output rob_head_valid, rob_head, csr_rdata, wb_ready,
    input  req_ready, csr_set, csr_name, csr_wdata, csr_pc, ecall, mret,
    input  wb_valid, wb_rob, wb_rd_en, wb_data, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_24080006_csr_ctrl.sv
// Serialising CSR/ECALL/MRET initiator: holds one op until it reaches the ROB head, performs a
// single CSR file access, then returns the old value (or a trap redirect) to completion.
module ysyx_24080006_csr_ctrl
  import OoO_pkg::*;
#(
  parameter int unsigned ROB_IDX_W = 4
) (
  input logic                      clock,
  input logic                      reset,
  ysyx_24080006_csr_ctrl_if.slave  io_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] K_ECALL = 2'd1;
  localparam logic [1:0] K_MRET  = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           r_kind;
  csr_op_e              r_op;
  logic [11:0]          r_csr;
  logic [31:0]          r_src;
  logic [31:0]          r_pc;
  logic [ROB_IDX_W-1:0] r_rob;
  logic                 r_rd_en;
  logic [31:0]          r_rdata;

  logic w_accept;
  logic w_go;
  logic w_is_ecall;
  logic w_is_mret;
  logic w_is_trap;
  logic w_resp;

  assign w_is_ecall = (r_kind == K_ECALL);
  assign w_is_mret  = (r_kind == K_MRET);
  assign w_is_trap  = w_is_ecall | w_is_mret;
  assign w_resp     = (r_state == S_RESP);

  assign w_accept = io_bus.req_valid & io_bus.req_ready;
  // Flush and reset both veto the access so a killed op never touches the CSR file.
  assign w_go = (r_state == S_HOLD) & io_bus.rob_head_valid & (io_bus.rob_head == r_rob) &
                ~io_bus.flush & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kind  <= 2'd0;
      r_op    <= CSR_READ;
      r_csr   <= 12'h0;
      r_src   <= 32'h0;
      r_pc    <= 32'h0;
      r_rob   <= '0;
      r_rd_en <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_HOLD;
            r_kind  <= io_bus.req_kind;
            r_op    <= io_bus.req_op;
            r_csr   <= io_bus.req_csr;
            r_src   <= io_bus.req_src;
            r_pc    <= io_bus.req_pc;
            r_rob   <= io_bus.req_rob;
            r_rd_en <= io_bus.req_rd_en;
          end
        end
        S_HOLD: begin
          if (io_bus.flush) begin
            r_state <= S_IDLE;
          end else if (w_go) begin
            r_rdata <= io_bus.csr_rdata;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // A flush here drops the writeback; the CSR side effect has already happened.
          if (io_bus.wb_ready | io_bus.flush) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    io_bus.req_ready          = (r_state == S_IDLE) & ~io_bus.flush & ~reset;

    io_bus.csr_set.csr_enable = w_go;
    io_bus.csr_set.csr_op     = w_is_trap ? CSR_READ : r_op;
    io_bus.csr_name           = w_is_ecall ? CSR_MTVEC : (w_is_mret ? CSR_MEPC : r_csr);
    io_bus.csr_wdata          = r_src;
    io_bus.csr_pc             = r_pc;
    io_bus.ecall              = w_go & w_is_ecall;
    io_bus.mret               = w_go & w_is_mret;

    io_bus.wb_valid           = w_resp;
    io_bus.wb_rob             = w_resp ? r_rob : '0;
    io_bus.wb_rd_en           = w_resp & ~w_is_trap & r_rd_en;
    io_bus.wb_data            = (w_resp & ~w_is_trap) ? r_rdata : 32'h0;
    io_bus.redirect_valid     = w_resp & w_is_trap;
    io_bus.redirect_pc        = (w_resp & w_is_trap) ? {r_rdata[31:2], 2'b00} : 32'h0;
  end

endmodule

// File: tb/tb_ysyx_24080006_csr_ctrl.sv
// Bench for the CSR controller: directed vector table, hand-written reset/flush sequences and
// randomized ops checked against a transaction-level CSR-state model.
module tb_ysyx_24080006_csr_ctrl;
  import OoO_pkg::*;

  typedef struct {
    logic [1:0]  kind;
    csr_op_e     op;
    logic [11:0] csr;
    logic [31:0] src;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic        rd_en;
    int          delay;
    int          stall;
    int          fmode;  // 0 none, 1 flush on head match, 2 flush in RESP
    logic [31:0] exp;    // old CSR value, or redirect target for traps
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int unsigned acc_cnt = 0;

  always #5 clock = ~clock;

  ysyx_24080006_csr_ctrl_if #(.ROB_IDX_W(4)) bus ();

  ysyx_24080006_csr_ctrl #(.ROB_IDX_W(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  // CSR file stand-in: combinational read, write on the access edge, mepc capture on ecall.
  logic [31:0] csrf [4096];
  assign bus.csr_rdata = csrf[bus.csr_name];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) csrf[i] <= 32'h0;
      csrf[CSR_MSTATUS] <= 32'h1800;
    end else if (bus.csr_set.csr_enable) begin
      acc_cnt <= acc_cnt + 1;
      case (bus.csr_set.csr_op)
        CSR_WRITE: csrf[bus.csr_name] <= bus.csr_wdata;
        CSR_SET:   csrf[bus.csr_name] <= csrf[bus.csr_name] | bus.csr_wdata;
        CSR_CLEAR: csrf[bus.csr_name] <= csrf[bus.csr_name] & ~bus.csr_wdata;
        default: ;
      endcase
      if (bus.ecall) csrf[CSR_MEPC] <= bus.csr_pc;
    end
  end

  // Reference: architectural CSR state as a sparse map.
  logic [31:0] m_csr [int];

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    if (m_csr.exists(int'(a))) return m_csr[int'(a)];
    return (a == CSR_MSTATUS) ? 32'h1800 : 32'h0;
  endfunction

  task automatic model_exec(input vec_t t, output logic [31:0] data, output logic [31:0] redir);
    logic [31:0] old;
    data  = 32'h0;
    redir = 32'h0;
    if (t.kind == 2'd1) begin
      redir = m_rd(CSR_MTVEC) & ~32'h3;
      m_csr[int'(CSR_MEPC)] = t.pc;
    end else if (t.kind == 2'd2) begin
      redir = m_rd(CSR_MEPC) & ~32'h3;
    end else begin
      old  = m_rd(t.csr);
      data = old;
      if (t.op == CSR_WRITE) m_csr[int'(t.csr)] = t.src;
      else if (t.op == CSR_SET) m_csr[int'(t.csr)] = old | t.src;
      else if (t.op == CSR_CLEAR) m_csr[int'(t.csr)] = old & ~t.src;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] kind, input csr_op_e op, input logic [11:0] csr,
                              input logic [31:0] src, input logic [31:0] pc, input logic [3:0] rob,
                              input logic rd_en, input int delay, input int stall, input int fmode,
                              input logic [31:0] exp);
    vec_t v;
    v.kind = kind; v.op = op; v.csr = csr; v.src = src; v.pc = pc; v.rob = rob;
    v.rd_en = rd_en; v.delay = delay; v.stall = stall; v.fmode = fmode; v.exp = exp;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_kind = 2'd0; bus.req_op = CSR_READ;
    bus.req_csr = 12'h0; bus.req_src = 32'h0; bus.req_pc = 32'h0; bus.req_rob = 4'd0;
    bus.req_rd_en = 1'b0; bus.rob_head_valid = 1'b0; bus.rob_head = 4'd0; bus.wb_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t t, input bit use_tab);
    logic [31:0] e_data, e_redir;
    logic        trap;
    int unsigned acc0;
    trap = (t.kind == 2'd1) || (t.kind == 2'd2);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_kind = t.kind; bus.req_op = t.op; bus.req_csr = t.csr;
    bus.req_src = t.src; bus.req_pc = t.pc; bus.req_rob = t.rob; bus.req_rd_en = t.rd_en;
    bus.rob_head_valid = 1'b0; bus.flush = 1'b0; bus.wb_ready = 1'b0;
    #1 chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    for (int d = 0; d < t.delay; d++) begin
      @(negedge clock);
      bus.req_valid = 1'b0;
      if (d % 2 == 0) begin bus.rob_head_valid = 1'b0; bus.rob_head = t.rob; end
      else begin bus.rob_head_valid = 1'b1; bus.rob_head = t.rob + 4'd1; end
      #1 chk("no_access_wait", {29'd0, bus.csr_set.csr_enable, bus.ecall, bus.mret}, 32'd0);
      chk("hold_not_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clock);
    bus.req_valid = 1'b0; bus.rob_head_valid = 1'b1; bus.rob_head = t.rob;
    bus.flush = (t.fmode == 1);
    acc0 = acc_cnt;
    #1;
    if (t.fmode == 1) begin
      chk("flush_no_access", {29'd0, bus.csr_set.csr_enable, bus.ecall, bus.mret}, 32'd0);
      @(negedge clock);
      bus.flush = 1'b0; bus.rob_head_valid = 1'b0;
      #1 chk("flush_ready", 32'(bus.req_ready), 32'd1);
      chk("flush_no_wb", 32'(bus.wb_valid), 32'd0);
      chk("flush_acc_cnt", acc_cnt, acc0);
      return;
    end
    chk("acc_enable", 32'(bus.csr_set.csr_enable), 32'd1);
    chk("acc_op", 32'(bus.csr_set.csr_op), trap ? 32'(CSR_READ) : 32'(t.op));
    chk("acc_name", 32'(bus.csr_name),
        (t.kind == 2'd1) ? 32'(CSR_MTVEC) : (t.kind == 2'd2) ? 32'(CSR_MEPC) : 32'(t.csr));
    chk("acc_ecall", 32'(bus.ecall), 32'(t.kind == 2'd1));
    chk("acc_mret", 32'(bus.mret), 32'(t.kind == 2'd2));
    if (!trap) chk("acc_wdata", bus.csr_wdata, t.src);
    if (t.kind == 2'd1) chk("acc_pc", bus.csr_pc, t.pc);
    model_exec(t, e_data, e_redir);
    if (use_tab) begin
      if (trap) e_redir = t.exp;
      else e_data = t.exp;
    end
    for (int s = 0; s <= t.stall; s++) begin
      @(negedge clock);
      bus.rob_head_valid = 1'b0;
      bus.wb_ready = (s == t.stall) && (t.fmode != 2);
      bus.flush = (s == t.stall) && (t.fmode == 2);
      #1 chk("wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("wb_rob", 32'(bus.wb_rob), 32'(t.rob));
      chk("wb_rd_en", 32'(bus.wb_rd_en), trap ? 32'd0 : 32'(t.rd_en));
      chk("wb_data", bus.wb_data, trap ? 32'h0 : e_data);
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(trap));
      if (trap) chk("redirect_pc", bus.redirect_pc, e_redir);
      chk("resp_no_access", 32'(bus.csr_set.csr_enable), 32'd0);
      chk("resp_not_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clock);
    bus.wb_ready = 1'b0; bus.flush = 1'b0;
    #1 chk("wb_done", 32'(bus.wb_valid), 32'd0);
    chk("ready_after_wb", 32'(bus.req_ready), 32'd1);
    chk("access_once", acc_cnt, acc0 + 1);
  endtask

  vec_t tab [15];
  vec_t rv;
  logic [11:0] rcsr [4];

  initial begin
    tab[0]  = mk(2'd0, CSR_WRITE, CSR_MTVEC,    32'h8000_0104, 32'h0,         4'd3,  1, 0, 0, 0,
                 32'h0);
    tab[1]  = mk(2'd0, CSR_READ,  CSR_MTVEC,    32'h0,         32'h0,         4'd4,  1, 0, 0, 0,
                 32'h8000_0104);
    tab[2]  = mk(2'd0, CSR_SET,   CSR_MSTATUS,  32'h8,         32'h0,         4'd5,  1, 4, 0, 0,
                 32'h1800);
    tab[3]  = mk(2'd0, CSR_WRITE, CSR_MTVEC,    32'h3000_0200, 32'h0,         4'd6,  1, 0, 0, 0,
                 32'h8000_0104);
    tab[4]  = mk(2'd1, CSR_READ,  12'h0,        32'h0,         32'h3000_0010, 4'd7,  1, 0, 0, 0,
                 32'h3000_0200);
    tab[5]  = mk(2'd0, CSR_WRITE, CSR_MEPC,     32'h3000_0014, 32'h0,         4'd8,  1, 0, 0, 0,
                 32'h3000_0010);
    tab[6]  = mk(2'd2, CSR_READ,  12'h0,        32'h0,         32'h0,         4'd9,  1, 1, 0, 0,
                 32'h3000_0014);
    tab[7]  = mk(2'd0, CSR_WRITE, CSR_MSCRATCH, 32'hdead_beef, 32'h0,         4'd10, 1, 2, 0, 1,
                 32'h0);
    tab[8]  = mk(2'd0, CSR_READ,  CSR_MSCRATCH, 32'h0,         32'h0,         4'd11, 1, 0, 3, 0,
                 32'h0);
    tab[9]  = mk(2'd3, CSR_SET,   CSR_MSCRATCH, 32'h5,         32'h0,         4'd12, 0, 0, 0, 0,
                 32'h0);
    tab[10] = mk(2'd0, CSR_CLEAR, CSR_MSCRATCH, 32'h4,         32'h0,         4'd13, 1, 0, 1, 2,
                 32'h5);
    tab[11] = mk(2'd0, CSR_READ,  CSR_MSCRATCH, 32'h0,         32'h0,         4'd14, 1, 0, 0, 0,
                 32'h1);
    tab[12] = mk(2'd0, CSR_WRITE, CSR_MTVEC,    32'h3000_0203, 32'h0,         4'd15, 1, 0, 0, 0,
                 32'h3000_0200);
    tab[13] = mk(2'd1, CSR_READ,  12'h0,        32'h0,         32'h4000_0000, 4'd0,  1, 0, 2, 0,
                 32'h3000_0200);
    tab[14] = mk(2'd0, CSR_READ,  CSR_MSTATUS,  32'h0,         32'h0,         4'd1,  1, 0, 0, 0,
                 32'h1808);
    rcsr[0] = CSR_MSCRATCH; rcsr[1] = CSR_MTVEC; rcsr[2] = CSR_MEPC; rcsr[3] = CSR_MSTATUS;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 chk("reset_ready_low", 32'(bus.req_ready), 32'd0);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset_csr_set", 32'(bus.csr_set), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
    m_csr.delete();

    for (int i = 0; i < 15; i++) run_op(tab[i], 1'b1);

    // Flush in IDLE blocks acceptance.
    @(negedge clock);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_kind = 2'd0; bus.req_op = CSR_WRITE;
    bus.req_csr = CSR_MSCRATCH; bus.req_src = 32'h77; bus.req_rob = 4'd2;
    #1 chk("idle_flush_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    #1 chk("idle_flush_no_accept", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 60; i++) begin
      rv = mk(2'($urandom_range(0, 3)), csr_op_e'($urandom_range(0, 3)),
              rcsr[$urandom_range(0, 3)], $urandom, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0, 32'h0);
      run_op(rv, 1'b0);
    end

    // Reset while a writeback is pending.
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_kind = 2'd1; bus.req_op = CSR_READ; bus.req_csr = 12'h0;
    bus.req_pc = 32'h1234_5678; bus.req_src = 32'hffff_ffff; bus.req_rob = 4'd9;
    bus.req_rd_en = 1'b1; bus.rob_head_valid = 1'b1; bus.rob_head = 4'd9; bus.wb_ready = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    #1 chk("rst_seq_access", 32'(bus.ecall), 32'd1);
    @(negedge clock);
    bus.rob_head_valid = 1'b0;
    #1 chk("rst_seq_wb_valid", 32'(bus.wb_valid), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst_seq_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    #1 chk("rst_seq_wb_valid0", 32'(bus.wb_valid), 32'd0);
    chk("rst_seq_redirect0", {31'd0, bus.redirect_valid} | bus.redirect_pc, 32'd0);
    chk("rst_seq_wb0", {27'd0, bus.wb_rob, bus.wb_rd_en} | bus.wb_data, 32'd0);
    chk("rst_seq_csr0", {29'd0, bus.csr_set} | {20'd0, bus.csr_name}, 32'd0);
    chk("rst_seq_data0", bus.csr_wdata | bus.csr_pc, 32'd0);
    chk("rst_seq_pulse0", {30'd0, bus.ecall, bus.mret}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rst_seq_ready", 32'(bus.req_ready), 32'd1);
    m_csr.delete();

    run_op(mk(2'd0, CSR_READ, CSR_MSTATUS, 32'h0, 32'h0, 4'd4, 1, 0, 0, 0, 32'h1800), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_csr_ctrl.md
# ysyx_24080006_csr_ctrl

Serialising initiator for the CSR register file in the OoO backend. Accepts one CSR/ECALL/MRET micro-op from dispatch and holds it until it is the ROB head. It then drives a single-cycle access on the CSR file port (`csr_set`/`csr_name`/`csr_wdata`/`csr_pc`/`ecall`/`mret`) and captures `csr_rdata`. Finally it returns a writeback, plus a PC redirect for traps, to the completion stage.

## Interface
- `ROB_IDX_W`, default 4: ROB index width.
- `clock`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  pipeline flush; kills any held op.
- `req_valid`  in  1  dispatch request valid.
- `req_ready`  out  1  = (state==IDLE) & ~flush & ~reset.
- `req_kind`  in  2  0=CSR op, 1=ECALL, 2=MRET; 3 is treated as a CSR op.
- `req_op`  in  csr_op_e (OoO_pkg)  CSR_READ/WRITE/SET/CLEAR; the decoder has already demoted rs1=x0 / zimm=0 set/clear to CSR_READ.
- `req_csr`  in  12  CSR address.
- `req_src`  in  32  rs1 value or zero-extended zimm.
- `req_pc`  in  32  instruction PC.
- `req_rob`  in  ROB_IDX_W  ROB tag.
- `req_rd_en`  in  1  rd != x0.
- `rob_head_valid`  in  1  ROB head slot occupied.
- `rob_head`  in  ROB_IDX_W  ROB head tag.
- `csr_set`  out  csr_set_t  {csr_enable, csr_op} to the CSR file.
- `csr_name`  out  12  CSR address.
- `csr_wdata`  out  32  write source.
- `csr_pc`  out  32  PC for mepc.
- `ecall`  out  1  trap-entry pulse.
- `mret`  out  1  trap-return pulse.
- `csr_rdata`  in  32  combinational read data from the CSR file.
- `wb_valid`  out  1  writeback valid.
- `wb_ready`  in  1  completion stage accepts.
- `wb_rob`  out  ROB_IDX_W  tag of the completing op.
- `wb_rd_en`  out  1  register write enable.
- `wb_data`  out  32  old CSR value.
- `redirect_valid`  out  1  trap redirect; asserted only together with `wb_valid`.
- `redirect_pc`  out  32  redirect target.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - HOLD: op latched, waiting for ROB head.
  - RESP: writeback pending.
- **IDLE → HOLD** on `req_valid & req_ready`. All `req_*` fields are latched into a held-op register.
- **Access condition:** `go = (state==HOLD) & rob_head_valid & (rob_head==held_rob) & ~flush`.
- **While `go` is high (one cycle), by held kind:**
  - CSR op: csr_enable=1, csr_op=held_op, csr_name=held_csr, csr_wdata=held_src.
  - ECALL: csr_enable=1, csr_op=CSR_READ, csr_name=CSR_MTVEC, ecall=1, csr_pc=held_pc.
  - MRET: csr_enable=1, csr_op=CSR_READ, csr_name=CSR_MEPC, mret=1.
- **Same edge as `go`:** capture `csr_rdata` into rdata_q and move HOLD → RESP.
- **When `go` is low:** csr_enable, ecall and mret are all 0. csr_op, csr_name, csr_wdata and csr_pc hold the latched values but have no effect.
- **RESP outputs:**
  - wb_valid=1, wb_rob=held_rob.
  - CSR op: wb_rd_en=held_rd_en, wb_data=rdata_q, redirect_valid=0.
  - ECALL/MRET: wb_rd_en=0, wb_data=0, redirect_valid=1, redirect_pc=rdata_q with bits [1:0] forced to 0.
- **RESP → IDLE** on `wb_ready`. While `wb_ready` is low, all RESP outputs hold stable.
- **Flush:**
  - In HOLD: go to IDLE; no CSR access occurs (`go` is gated by flush).
  - In RESP: go to IDLE; the writeback is dropped, and the side effect already performed stands.
  - In IDLE: blocks acceptance.
- **Reset:** state=IDLE and held/rdata registers cleared. All outputs read 0, including req_ready while reset is asserted; req_ready is 1 on the first cycle after reset deasserts.
- **Ordering:** one op in flight at most; no bypass; CSR file side effects happen exactly once per accepted, unflushed op.

## Timing
- Minimum latency: accept at cycle 0, access at cycle 1 if the tag is at the head, wb_valid at cycle 2.
- HOLD dwell is unbounded, set by ROB head arrival.
- `req_ready` deasserts the cycle after acceptance. The next accept is possible in the cycle after `wb_valid & wb_ready`.
- Old-value semantics: wb_data is the `csr_rdata` sampled in the access cycle, i.e. the pre-write value.
- Head match and flush in the same cycle: flush wins; no access.
- `wb_ready` and flush in RESP in the same cycle: the handshake completes as a transfer, then state goes to IDLE.

## Test plan
- CSRRW mscratch-like to CSR_MTVEC, src=0x8000_0104, rob=3, head=3 immediately → csr_enable for exactly 1 cycle at cycle 1 with op WRITE; wb at cycle 2 with wb_data = old mtvec (0 after reset); a subsequent READ returns 0x8000_0104.
- CSRRS MSTATUS src=0x8, rob=5, head=2 for 4 cycles then 5 → no csr_enable during the wait; single access in the cycle head becomes 5; wb_data=0x1800.
- ECALL pc=0x3000_0010 with mtvec=0x3000_0200 → ecall=1 and csr_pc=0x3000_0010 for 1 cycle; redirect_valid=1, redirect_pc=0x3000_0200, wb_rd_en=0.
- MRET with mepc=0x3000_0014 → mret pulse; redirect_pc=0x3000_0014.
- Flush in HOLD on the cycle head matches → no csr_enable/ecall; state IDLE; req_ready=1 the next cycle; no wb_valid.
- wb_ready held low 3 cycles in RESP → wb_valid/wb_data/redirect stable; reset asserted mid-RESP → all outputs 0 next cycle, req_ready=1 after release.
